// File: rtl/seq_add_sub_unit.sv
// seq_add_sub_unit
// Multi-cycle signed/unsigned adder-subtractor. Each operation adds CHUNK bits per
// clock using a ripple carry held in a register, so one operation takes NCHUNK =
// WIDTH/CHUNK cycles. Operands are captured in IDLE. The result and the status flags
// are registered on entry to DONE, and the consumer takes them with a valid/ready
// handshake.
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous active-high reset
//   IN_VALID   operand request valid
//   IN_READY   unit can accept operands (IDLE only)
//   SUB        0: A+B, 1: A-B (A + ~B + 1)
//   A, B       operands, WIDTH bits
//   SAT        saturate on signed overflow (only with SEQ_ADD_SUB_SATURATE_EN)
//   OUT_VALID  RESULT and flags valid (DONE)
//   OUT_READY  consumer accepts result
//   RESULT     sum/difference modulo 2^WIDTH (or clamped when saturating)
//   COUT       raw carry out of MSB (1 = no borrow for subtraction)
//   OVF        signed overflow
//   ZERO       RESULT == 0
//   NEG        RESULT[WIDTH-1]
//
// Optional feature macro: SEQ_ADD_SUB_SATURATE_EN (adds SAT port and clamping).

module seq_add_sub_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SEQ_ADD_SUB_SATURATE_EN
  input  logic             SAT,
`endif
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO,
  output logic             NEG
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned SH     = WIDTH - CHUNK;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (WIDTH < 2) begin : g_bad_width
    $error("seq_add_sub_unit: WIDTH must be >= 2");
  end
  if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("seq_add_sub_unit: WIDTH must be a multiple of CHUNK");
  end

  logic [1:0]       state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  // Operands shift right by CHUNK each RUN cycle, so the active slice is always at
  // the bottom. This is equivalent to indexing slice [cnt*CHUNK +: CHUNK].
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  // The partial sum fills from the top and is complete after the last slice.
  logic [WIDTH-1:0] sum_q;
  logic             sat_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] sum_next;
  logic             last;
  logic             c_msb;
  logic             ovf_raw;
  logic [WIDTH-1:0] res_fin;
  logic             sat_in;

`ifdef SEQ_ADD_SUB_SATURATE_EN
  assign sat_in = SAT;
`else
  assign sat_in = 1'b0;
`endif

  always_comb begin
    a_sl     = a_q[CHUNK-1:0];
    b_sl     = b_q[CHUNK-1:0];
    csum     = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
    sum_next = (sum_q >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << SH);
    last     = (cnt_q == CW'(NCHUNK - 1));
    // Carry into the MSB is recovered from the MSB sum bit. On the last slice,
    // a_sl/b_sl hold the operand MSBs.
    c_msb    = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ csum[CHUNK-1];
    ovf_raw  = c_msb ^ csum[CHUNK];
    res_fin  = sum_next;
    if (sat_q && ovf_raw) begin
      // Overflow needs both effective operands to share a sign, so A's MSB gives
      // the overflow direction.
      if (a_sl[CHUNK-1]) begin
        res_fin = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        res_fin = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      sat_q    <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (IN_VALID) begin
            a_q     <= A;
            b_q     <= B ^ {WIDTH{SUB}};
            carry_q <= SUB;
            cnt_q   <= '0;
            sum_q   <= '0;
            sat_q   <= sat_in;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          sum_q   <= sum_next;
          carry_q <= csum[CHUNK];
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            result_q <= res_fin;
            cout_q   <= csum[CHUNK];
            ovf_q    <= ovf_raw;
            zero_q   <= (res_fin == '0);
            neg_q    <= res_fin[WIDTH-1];
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = (state_q == DONE);
  assign RESULT    = result_q;
  assign COUT      = cout_q;
  assign OVF       = ovf_q;
  assign ZERO      = zero_q;
  assign NEG       = neg_q;

endmodule

// File: tb/tb_seq_add_sub_unit.sv
// Directed self-checking bench for seq_add_sub_unit. It instantiates three
// configurations: 8/2, 16/16 (single-cycle RUN) and 16/4.
module tb_seq_add_sub_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8-bit, CHUNK=2
  logic       iv8 = 0, ir8, sub8 = 0, ov8, or8 = 0, c8, o8, z8, n8;
  logic [7:0] a8 = 0, b8 = 0, r8;
  logic       sat8 = 0;
  // 16-bit, CHUNK=16
  logic        iva = 0, ira, suba = 0, ova, ora = 0, ca, oa, za, na;
  logic [15:0] aa = 0, ba = 0, ra;
  logic        sata = 0;
  // 16-bit, CHUNK=4
  logic        ivb = 0, irb, subb = 0, ovb, orb = 0, cb, ob, zb, nb;
  logic [15:0] ab = 0, bb = 0, rb;
  logic        satb = 0;

  seq_add_sub_unit #(.WIDTH(8), .CHUNK(2)) u8 (
    .CLK(clk), .RST(rst), .IN_VALID(iv8), .IN_READY(ir8), .SUB(sub8), .A(a8), .B(b8),
`ifdef SEQ_ADD_SUB_SATURATE_EN
    .SAT(sat8),
`endif
    .OUT_VALID(ov8), .OUT_READY(or8), .RESULT(r8), .COUT(c8), .OVF(o8), .ZERO(z8),
    .NEG(n8)
  );

  seq_add_sub_unit #(.WIDTH(16), .CHUNK(16)) u16a (
    .CLK(clk), .RST(rst), .IN_VALID(iva), .IN_READY(ira), .SUB(suba), .A(aa), .B(ba),
`ifdef SEQ_ADD_SUB_SATURATE_EN
    .SAT(sata),
`endif
    .OUT_VALID(ova), .OUT_READY(ora), .RESULT(ra), .COUT(ca), .OVF(oa), .ZERO(za),
    .NEG(na)
  );

  seq_add_sub_unit #(.WIDTH(16), .CHUNK(4)) u16b (
    .CLK(clk), .RST(rst), .IN_VALID(ivb), .IN_READY(irb), .SUB(subb), .A(ab), .B(bb),
`ifdef SEQ_ADD_SUB_SATURATE_EN
    .SAT(satb),
`endif
    .OUT_VALID(ovb), .OUT_READY(orb), .RESULT(rb), .COUT(cb), .OVF(ob), .ZERO(zb),
    .NEG(nb)
  );

  // Runs one 8-bit operation and returns the presented result, flags and the number
  // of edges from capture to OUT_VALID. Consumes the result afterwards.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                      input logic sat, output logic [7:0] res, output logic [3:0] fl,
                      output int lat);
    @(negedge clk);
    a8 = a; b8 = b; sub8 = sub; sat8 = sat; iv8 = 1; or8 = 0;
    @(posedge clk); #1;
    iv8 = 0; lat = 0;
    while (!ov8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = r8;
    fl  = {c8, o8, z8, n8};
    @(negedge clk);
    or8 = 1;
    @(posedge clk); #1;
    or8 = 0;
  endtask

  task automatic run16(input int which, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output logic [3:0] fl, output int lat);
    @(negedge clk);
    if (which == 0) begin aa = a; ba = b; suba = 0; iva = 1; end
    else begin ab = a; bb = b; subb = 0; ivb = 1; end
    @(posedge clk); #1;
    iva = 0; ivb = 0; lat = 0;
    while (!((which == 0) ? ova : ovb) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = (which == 0) ? ra : rb;
    fl  = (which == 0) ? {ca, oa, za, na} : {cb, ob, zb, nb};
    @(negedge clk);
    ora = 1; orb = 1;
    @(posedge clk); #1;
    ora = 0; orb = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ov8 !== 1'b0 || r8 !== 8'h00 || {c8, o8, z8, n8} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: ov=%b res=%h flags=%b, required ov=0 res=00 flags=0000",
               ov8, r8, {c8, o8, z8, n8});
    end
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (ir8 !== 1'b1 || ira !== 1'b1 || irb !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: %b%b%b, required 111", ir8, ira, irb);
    end
  endtask

  task automatic test_add;
    logic [7:0] res; logic [3:0] fl; int lat;
    run8(8'h3C, 8'h05, 1'b0, 1'b0, res, fl, lat);
    checks++;
    if (res !== 8'h41 || fl !== 4'b0000) begin
      errors++;
      $display("FAIL add_3c_05: res=%h flags=%b, required 41 0000", res, fl);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL add_latency: %0d, required 4", lat);
    end
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
      errors++;
      $display("FAIL add_back_idle: ir=%b ov=%b, required ir=1 ov=0", ir8, ov8);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] res; logic [3:0] fl; int lat;
    run8(8'h7F, 8'h01, 1'b0, 1'b0, res, fl, lat);
    checks++;
    if (res !== 8'h80 || fl !== 4'b0101) begin
      errors++;
      $display("FAIL ovf_7f_01: res=%h cozn=%b, required 80 0101", res, fl);
    end
`ifdef SEQ_ADD_SUB_SATURATE_EN
    run8(8'h7F, 8'h01, 1'b0, 1'b1, res, fl, lat);
    checks++;
    if (res !== 8'h7F || fl !== 4'b0100) begin
      errors++;
      $display("FAIL sat_7f_01: res=%h cozn=%b, required 7f 0100", res, fl);
    end
`endif
  endtask

  task automatic test_sub;
    logic [7:0] res; logic [3:0] fl; int lat;
    run8(8'h05, 8'h05, 1'b1, 1'b0, res, fl, lat);
    checks++;
    if (res !== 8'h00 || fl !== 4'b1010) begin
      errors++;
      $display("FAIL sub_05_05: res=%h cozn=%b, required 00 1010", res, fl);
    end
    run8(8'h03, 8'h05, 1'b1, 1'b0, res, fl, lat);
    checks++;
    if (res !== 8'hFE || fl !== 4'b0001) begin
      errors++;
      $display("FAIL sub_03_05: res=%h cozn=%b, required fe 0001", res, fl);
    end
    run8(8'h80, 8'h01, 1'b1, 1'b0, res, fl, lat);
    checks++;
    if (res !== 8'h7F || fl !== 4'b1100) begin
      errors++;
      $display("FAIL sub_80_01: res=%h cozn=%b, required 7f 1100", res, fl);
    end
`ifdef SEQ_ADD_SUB_SATURATE_EN
    run8(8'h80, 8'h01, 1'b1, 1'b1, res, fl, lat);
    checks++;
    if (res !== 8'h80 || fl !== 4'b1101) begin
      errors++;
      $display("FAIL sat_80_01: res=%h cozn=%b, required 80 1101", res, fl);
    end
`endif
  endtask

  task automatic test_backpressure;
    int lat;
    int bad;
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; sub8 = 0; sat8 = 0; iv8 = 1; or8 = 0;
    @(posedge clk); #1;
    iv8 = 0; lat = 0;
    while (!ov8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (ov8 !== 1'b1 || r8 !== 8'h46) begin
      errors++;
      $display("FAIL bp_first_result: ov=%b res=%h, required 1 46", ov8, r8);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a8 = 8'hA0 + 8'(i); b8 = 8'h0F; sub8 = 1; iv8 = (i % 2 == 0);
      @(posedge clk); #1;
      if (r8 !== 8'h46 || ov8 !== 1'b1 || ir8 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d bad cycles, last res=%h ov=%b ir=%b, required 0 (46 1 0)",
               bad, r8, ov8, ir8);
    end
    @(negedge clk);
    iv8 = 0; or8 = 1;
    @(posedge clk); #1;
    or8 = 0;
    checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1 || r8 !== 8'h46) begin
      errors++;
      $display("FAIL bp_release: ov=%b ir=%b res=%h, required 0 1 46", ov8, ir8, r8);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [7:0] res; logic [3:0] fl; int lat;
    int seen;
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h11; sub8 = 0; iv8 = 1; or8 = 1;
    @(posedge clk); #1;
    iv8 = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    checks++;
    if (ov8 !== 1'b0 || r8 !== 8'h00 || ir8 !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_reset: ov=%b res=%h ir=%b, required 0 00 1", ov8, r8, ir8);
    end
    #2 rst = 0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ov8) seen++;
    end
    checks++;
    if (seen != 0 || ir8 !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_no_partial: valid seen %0d ir=%b, required 0 1", seen, ir8);
    end
    or8 = 0;
    run8(8'h10, 8'h20, 1'b0, 1'b0, res, fl, lat);
    checks++;
    if (res !== 8'h30 || fl !== 4'b0000) begin
      errors++;
      $display("FAIL after_reset_add: res=%h cozn=%b, required 30 0000", res, fl);
    end
  endtask

  task automatic test_wide;
    logic [15:0] res; logic [3:0] fl; int lat;
    run16(0, 16'hFFFF, 16'h0001, res, fl, lat);
    checks++;
    if (res !== 16'h0000 || fl !== 4'b1010 || lat !== 1) begin
      errors++;
      $display("FAIL w16c16_ffff_1: res=%h cozn=%b lat=%0d, required 0000 1010 1",
               res, fl, lat);
    end
    run16(1, 16'hFFFF, 16'h0001, res, fl, lat);
    checks++;
    if (res !== 16'h0000 || fl !== 4'b1010 || lat !== 4) begin
      errors++;
      $display("FAIL w16c4_ffff_1: res=%h cozn=%b lat=%0d, required 0000 1010 4",
               res, fl, lat);
    end
    run16(1, 16'h7FFF, 16'h0001, res, fl, lat);
    checks++;
    if (res !== 16'h8000 || fl !== 4'b0101) begin
      errors++;
      $display("FAIL w16c4_7fff_1: res=%h cozn=%b, required 8000 0101", res, fl);
    end
    run16(0, 16'h1234, 16'h4321, res, fl, lat);
    checks++;
    if (res !== 16'h5555 || fl !== 4'b0000) begin
      errors++;
      $display("FAIL w16c16_1234_4321: res=%h cozn=%b, required 5555 0000", res, fl);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_add_sub_unit.md
Name: seq_add_sub_unit

Overview:
- Parametrised, multi-cycle, signed/unsigned adder-subtractor for the datapath.
- Successor to the fixed 8-bit combinational add/sub. Adds configurable width and a configurable number of bits processed per cycle (chunked ripple), a valid/ready handshake on both sides, registered results and status flags (carry, overflow, zero, negative).
- Sits between the operand register file and the writeback stage. A slow chunk width saves area at the cost of latency.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- CHUNK, 2, bits added per cycle. WIDTH % CHUNK == 0 is required; a violation is an elaboration error.
- NCHUNK, WIDTH/CHUNK, derived (localparam); number of processing cycles per operation.

Ports:
- CLK  input  1  clock. All state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  operand request valid.
- IN_READY  output  1  unit can accept operands. High only in IDLE.
- SUB  input  1  0 = A+B, 1 = A−B (two's complement: A + ~B + 1).
- A  input  WIDTH  first operand.
- B  input  WIDTH  second operand.
- OUT_VALID  output  1  result and flags valid.
- OUT_READY  input  1  consumer accepts result.
- RESULT  output  WIDTH  sum/difference, modulo 2^WIDTH.
- COUT  output  1  carry out of the MSB. For subtraction, 1 = no borrow (A ≥ B unsigned).
- OVF  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- ZERO  output  1  RESULT == 0.
- NEG  output  1  RESULT[WIDTH-1].

Behaviour:

Reset (RST high, asynchronous):
- State goes to IDLE.
- IN_READY=1 once RST is released; OUT_VALID=0.
- RESULT, COUT, OVF, ZERO, NEG all 0.
- Chunk counter, carry and operand registers all 0.
- Reset asserted mid-RUN or in DONE aborts the operation. No partial result is ever presented.

State machine:
- IDLE:
  - IN_READY=1.
  - On IN_VALID at an edge, capture A, B^{WIDTH{SUB}} and carry-in = SUB; counter=0; go to RUN.
  - Operands are sampled only at this edge; later changes to A/B/SUB are ignored.
- RUN:
  - IN_READY=0.
  - Each edge adds slice [counter*CHUNK +: CHUNK] with the running carry, stores the sum slice, updates the carry, and increments the counter.
  - On the last slice (counter == NCHUNK−1), also record the carry into the MSB, then go to DONE.
- DONE:
  - OUT_VALID=1.
  - RESULT and flags are loaded on the DONE-entry edge and stay stable while OUT_VALID && !OUT_READY.
  - On OUT_READY at an edge, go to IDLE and set OUT_VALID=0.

Timing and handshake rules:
- Latency: operands accepted at edge e0 → OUT_VALID high after edge e0+NCHUNK. For WIDTH=8, CHUNK=2, this is 4 cycles.
- Throughput: at most one operation per NCHUNK+2 cycles. A new operand is not accepted in the same cycle a result is consumed.
- IN_VALID while not in IDLE is ignored. The source must hold it until IN_READY.
- OUT_READY outside DONE has no effect.
- RESULT and flags hold their last values outside DONE; OUT_VALID qualifies them.

Flag edge cases:
- CHUNK == WIDTH gives single-cycle RUN (NCHUNK=1). Correct operation is required.
- Subtraction of equal operands → RESULT=0, ZERO=1, COUT=1, OVF=0.

Optional Feature:
- Macro: SEQ_ADD_SUB_SATURATE_EN.
- Defined: adds input port SAT (1 bit, sampled with the operands in IDLE).
  - When SAT=1 and signed overflow occurs, RESULT clamps to 2^(WIDTH−1)−1 on positive overflow, or −2^(WIDTH−1) on negative overflow.
  - Positive vs negative overflow is determined from the operand sign.
  - OVF still reports 1. COUT is unchanged, as the raw carry. ZERO and NEG are computed from the clamped RESULT.
  - SAT=0 behaves exactly as the undefined build.
- Undefined: no SAT port; RESULT always wraps modulo 2^WIDTH.

Test Plan:
- WIDTH=8, CHUNK=2, 0x3C + 0x05 with OUT_READY=1 → after 4 cycles RESULT=0x41, COUT=0, OVF=0, ZERO=0, NEG=0; IN_READY high again the next cycle.
- 0x7F + 0x01 → RESULT=0x80, OVF=1, NEG=1, COUT=0. With SEQ_ADD_SUB_SATURATE_EN and SAT=1 → RESULT=0x7F, OVF=1, NEG=0.
- Subtraction cases:
  - SUB=1, 0x05 − 0x05 → RESULT=0x00, ZERO=1, COUT=1.
  - 0x03 − 0x05 → RESULT=0xFE, COUT=0, NEG=1.
  - 0x80 − 0x01 → RESULT=0x7F, OVF=1 (with SAT=1 → 0x80).
- Backpressure: hold OUT_READY=0 for 5 cycles after OUT_VALID; change A/B and pulse IN_VALID meanwhile → RESULT stable, IN_READY=0, no new capture. Raise OUT_READY → IDLE next edge.
- Reset mid-RUN (after 2 of 4 chunks), asynchronous, between clock edges → OUT_VALID=0, RESULT=0, IN_READY=1 after release. A following 0x10+0x20 → 0x30.
- WIDTH=16, CHUNK=16 (single-cycle RUN) and WIDTH=16, CHUNK=4 (4 cycles): 0xFFFF + 0x0001 → RESULT=0x0000, COUT=1, ZERO=1, OVF=0 in both configurations.
